// File: rtl/ft_pkg.sv
// ---------------------------------------------------------------------------
// ft_pkg
// Shared definitions for the FT245 bus scheduler slice.
//   - ft_state_e : scheduler FSM states
//   - ft_grant_e : identity of the last granted requester
//   - default timing parameters, counter width
//   - packet framing symbols (header, trailer, error)
//   - ft_max     : helper used to size recovery phases
// ---------------------------------------------------------------------------
package ft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_RECOVER,
    WR_SETUP,
    WR_STROBE,
    WR_RECOVER
  } ft_state_e;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } ft_grant_e;

  localparam int unsigned FT_RD_LOW_CYC_DEF  = 5;
  localparam int unsigned FT_RD_HIGH_CYC_DEF = 4;
  localparam int unsigned FT_WR_HIGH_CYC_DEF = 4;
  localparam int unsigned FT_WR_LOW_CYC_DEF  = 4;
  localparam int unsigned FT_SYNC_STAGES_DEF = 2;

  // Phase counters hold (length - 1); all phase lengths must fit below 256.
  localparam int unsigned FT_CNT_W = 8;

  localparam logic [7:0]  FT_HDR_SYM = 8'h55;
  localparam int unsigned FT_HDR_LEN = 12;
  localparam logic [7:0]  FT_TRL_SYM = 8'hAA;
  localparam int unsigned FT_TRL_LEN = 8;
  localparam logic [7:0]  FT_ERR_SYM = 8'hEE;

  function automatic int unsigned ft_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ft_flag_sync.sv
// ---------------------------------------------------------------------------
// ft_flag_sync
// Multi-flop synchronizer for one asynchronous active-low FT245 flag.
// Resets to 1 so a flag reads as "not ready" until real samples arrive.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   d_i   in  raw asynchronous flag
//   q_o   out synchronized flag (last stage)
// ---------------------------------------------------------------------------
module ft_flag_sync
  import ft_pkg::*;
#(
  parameter int unsigned STAGES = FT_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; stage 0 is the only flop that sees the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ft_bus_sched.sv
// ---------------------------------------------------------------------------
// ft_bus_sched
// Schedules read and write transfers on an FT245-style parallel FIFO bus.
// Reads move bytes into a one-deep rx holding register (valid/ready out);
// writes take bytes from a valid/ready source and strobe them onto the bus.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   FT_RXFn, FT_TXEn asynchronous FT245 status flags (low = data / space)
//   FT_RDn, FT_WR    bus strobes (RDn active low, WR latched on falling edge)
//   FT_DATA_In/Out   shared bus data, FT_DATA_OE = FPGA drives the bus
//   rx_data/valid/ready  received byte stream
//   tx_data/valid/ready  transmit byte stream (tx_ready is a 1-cycle accept)
//   busy             scheduler not in IDLE
// ---------------------------------------------------------------------------
module ft_bus_sched
  import ft_pkg::*;
#(
  parameter int unsigned RD_LOW_CYC  = FT_RD_LOW_CYC_DEF,
  parameter int unsigned RD_HIGH_CYC = FT_RD_HIGH_CYC_DEF,
  parameter int unsigned WR_HIGH_CYC = FT_WR_HIGH_CYC_DEF,
  parameter int unsigned WR_LOW_CYC  = FT_WR_LOW_CYC_DEF,
  parameter int unsigned SYNC_STAGES = FT_SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       FT_RXFn,
  input  logic       FT_TXEn,
  output logic       FT_RDn,
  output logic       FT_WR,
  input  logic [7:0] FT_DATA_In,
  output logic [7:0] FT_DATA_Out,
  output logic       FT_DATA_OE,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  // Recovery phases must outlast the synchronizer so the flag sampled on
  // return to IDLE reflects the FT245 state after the strobe, not before it.
  localparam int unsigned RD_REC_CYC = ft_max(RD_HIGH_CYC, SYNC_STAGES + 1);
  localparam int unsigned WR_REC_CYC = ft_max(WR_LOW_CYC, SYNC_STAGES + 1);

  localparam logic [FT_CNT_W-1:0] RD_LOW_LOAD  = FT_CNT_W'(RD_LOW_CYC - 1);
  localparam logic [FT_CNT_W-1:0] RD_REC_LOAD  = FT_CNT_W'(RD_REC_CYC - 1);
  localparam logic [FT_CNT_W-1:0] WR_HIGH_LOAD = FT_CNT_W'(WR_HIGH_CYC - 1);
  localparam logic [FT_CNT_W-1:0] WR_REC_LOAD  = FT_CNT_W'(WR_REC_CYC - 1);

  ft_state_e state_q, state_d;
  ft_grant_e lastGrant_q, lastGrant_d;
  logic [FT_CNT_W-1:0] cnt_q, cnt_d;

  logic       rdn_q, rdn_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rxData_q, rxData_d;
  logic       rxValid_q, rxValid_d;

  logic rxfSync;
  logic txeSync;
  logic readElig;
  logic writeElig;
  logic grantRd;
  logic grantWr;
  logic rxLoad;

  ft_flag_sync #(.STAGES(SYNC_STAGES)) u_rxf_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (FT_RXFn),
    .q_o   (rxfSync)
  );

  ft_flag_sync #(.STAGES(SYNC_STAGES)) u_txe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (FT_TXEn),
    .q_o   (txeSync)
  );

  // A read may start while the holding register drains in the same cycle,
  // which keeps back-to-back reads free of a bubble.
  assign readElig  = ~rxfSync & (~rxValid_q | rx_ready);
  assign writeElig = ~txeSync & tx_valid;

  // Next-state logic. Each phase counter is loaded with (length - 1) on
  // entry and the phase ends on the cycle it reads zero, so every phase is
  // at least one cycle long. Contention alternates using lastGrant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    grantRd     = 1'b0;
    grantWr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (readElig && (!writeElig || lastGrant_q == GRANT_WR)) begin
          grantRd     = 1'b1;
          state_d     = RD_STROBE;
          cnt_d       = RD_LOW_LOAD;
          lastGrant_d = GRANT_RD;
        end else if (writeElig) begin
          grantWr     = 1'b1;
          state_d     = WR_SETUP;
          cnt_d       = '0;
          lastGrant_d = GRANT_WR;
        end
      end
      RD_STROBE: begin
        if (cnt_q == '0) begin
          state_d = RD_RECOVER;
          cnt_d   = RD_REC_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        cnt_d   = WR_HIGH_LOAD;
      end
      WR_STROBE: begin
        if (cnt_q == '0) begin
          state_d = WR_RECOVER;
          cnt_d   = WR_REC_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus strobes are registered from the next state so the pins come
  // straight off flops. OE stays up for one cycle after FT_WR falls so
  // the FT245 sees stable data across its latching edge.
  always_comb begin
    rdn_d  = (state_d != RD_STROBE);
    wr_d   = (state_d == WR_STROBE);
    oe_d   = (state_d == WR_SETUP) || (state_d == WR_STROBE) ||
             ((state_d == WR_RECOVER) && (state_q == WR_STROBE));
    dout_d = grantWr ? tx_data : dout_q;
  end

  // Holding register: the bus byte is captured on the last strobe cycle,
  // and a consumer handshake empties it on the following edge.
  always_comb begin
    rxLoad    = (state_q == RD_STROBE) && (cnt_q == '0);
    rxData_d  = rxData_q;
    rxValid_d = rxValid_q;
    if (rxValid_q && rx_ready) begin
      rxValid_d = 1'b0;
    end
    if (rxLoad) begin
      rxData_d  = FT_DATA_In;
      rxValid_d = 1'b1;
    end
  end

  // Reset parks the bus idle and drops any partially strobed byte; the
  // last grant starts as write so the first contention goes to read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lastGrant_q <= GRANT_WR;
      rdn_q       <= 1'b1;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      rdn_q       <= rdn_d;
      wr_q        <= wr_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rxData_q    <= rxData_d;
      rxValid_q   <= rxValid_d;
    end
  end

  assign FT_RDn      = rdn_q;
  assign FT_WR       = wr_q;
  assign FT_DATA_OE  = oe_q;
  assign FT_DATA_Out = dout_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign tx_ready    = grantWr;
  assign busy        = (state_q != IDLE);

endmodule
